// File: rtl/rec_play_pkg.sv
// Shared types for the record/playback controller.
//   state_t      : controller state codes, visible on o_state
//   speed_stat_t : playback speed direction (NORMAL / FAST / SLOW)
//   speed_code() : packs status and factor into the 5-bit player speed word
package rec_play_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_RECORD = 3'd3,
        ST_PAUSE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SPD_NORMAL = 2'd0,
        SPD_FAST   = 2'd1,
        SPD_SLOW   = 2'd2
    } speed_stat_t;

    // Bit 4 flags slow-down, bits 3:0 carry factor-1.
    function automatic logic [4:0] speed_code(input speed_stat_t stat, input logic [4:0] factor);
        return {stat == SPD_SLOW, 4'(factor - 5'd1)};
    endfunction

endpackage

// File: rtl/rec_play_speed.sv
// Playback speed state machine.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_en                : speed pulses honoured only while high (PLAY/PAUSE)
//   i_clr               : forces NORMAL/1 (new recording)
//   i_up, i_down        : single-cycle pulses; simultaneous pulses cancel
//   o_stat, o_factor    : registered speed status and factor
//   o_code              : registered player speed word
module rec_play_speed
    import rec_play_pkg::*;
#(
    parameter int MAX_SPEED = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic        i_up,
    input  logic        i_down,
    output speed_stat_t o_stat,
    output logic [4:0]  o_factor,
    output logic [4:0]  o_code
);

    localparam logic [4:0] MAX_F = 5'(MAX_SPEED);

    speed_stat_t stat_n;
    logic [4:0]  factor_n;
    logic        faster;

    // "faster" means moving further away from NORMAL in the current direction.
    assign faster = (o_stat == SPD_FAST) ? i_up : i_down;

    always_comb begin
        stat_n   = o_stat;
        factor_n = o_factor;
        if (i_clr) begin
            stat_n   = SPD_NORMAL;
            factor_n = 5'd1;
        end else if (i_en && (i_up ^ i_down)) begin
            case (o_stat)
                SPD_NORMAL: begin
                    stat_n   = i_up ? SPD_FAST : SPD_SLOW;
                    factor_n = 5'd2;
                end
                default: begin
                    if (faster) begin
                        factor_n = (o_factor >= MAX_F) ? MAX_F : o_factor + 5'd1;
                    end else if (o_factor == 5'd2) begin
                        stat_n   = SPD_NORMAL;
                        factor_n = 5'd1;
                    end else begin
                        factor_n = o_factor - 5'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stat   <= SPD_NORMAL;
            o_factor <= 5'd1;
            o_code   <= 5'd0;
        end else begin
            o_stat   <= stat_n;
            o_factor <= factor_n;
            o_code   <= speed_code(stat_n, factor_n);
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencing controller for a slotted SRAM.
// Build option: define LOOP_PLAY_EN to make end-of-play restart the slot
// instead of returning to IDLE.
// Ports:
//   i_clk, i_rst                      : BCLK, asynchronous active-high reset
//   i_start/i_stop/i_up/i_down        : debounced one-cycle button pulses
//   i_mode, i_slot                    : record(0)/play(1) and slot, read in IDLE
//   o_init_start / i_init_done        : codec init handshake
//   o_rec_start, o_rec_base,
//   i_rec_addr, i_rec_done            : recorder handshake
//   o_play_start, o_play_begin,
//   o_play_end, o_speed,
//   i_play_addr, i_play_done          : player handshake
//   o_addr_sel, o_state, o_speed_stat,
//   o_speed_factor, o_timer           : SRAM mux select and status
//
// state     | meaning
// INIT      | waiting for codec init to finish
// IDLE      | waiting for start
// PLAY      | player running from position
// RECORD    | recorder writing into the latched slot
// PAUSE     | player stopped, position held
module rec_play_ctrl
    import rec_play_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int SLOT_W    = 2,
    parameter int MAX_SPEED = 8,
    parameter int SR_LOG2   = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_mode,
    input  logic [SLOT_W-1:0] i_slot,
    output logic              o_init_start,
    input  logic              i_init_done,
    output logic              o_rec_start,
    output logic [ADDR_W-1:0] o_rec_base,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic              i_rec_done,
    output logic              o_play_start,
    output logic [ADDR_W-1:0] o_play_begin,
    output logic [ADDR_W-1:0] o_play_end,
    output logic [4:0]        o_speed,
    input  logic [ADDR_W-1:0] i_play_addr,
    input  logic              i_play_done,
    output logic              o_addr_sel,
    output logic [2:0]        o_state,
    output logic [1:0]        o_speed_stat,
    output logic [4:0]        o_speed_factor,
    output logic [4:0]        o_timer
);

    localparam int OFS_W  = ADDR_W - SLOT_W;
    localparam int LEN_W  = OFS_W + 1;
    localparam int N_SLOT = 1 << SLOT_W;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] s);
        return {s, {OFS_W{1'b0}}};
    endfunction

    state_t              state_r, state_n;
    logic [SLOT_W-1:0]   slot_r, slot_n;
    logic [ADDR_W-1:0]   pos_r, pos_n;
    logic [LEN_W-1:0]    len_r [N_SLOT];
    logic [ADDR_W-1:0]   base_r, rec_limit, play_end_n;
    logic [LEN_W-1:0]    rec_len;
    logic                loop_evt, rec_clr;
    speed_stat_t         spd_stat;

    assign base_r     = slot_base(slot_r);
    assign rec_limit  = {slot_r, {OFS_W{1'b1}}};
    assign rec_len    = LEN_W'(i_rec_addr - base_r) + LEN_W'(1);
    assign play_end_n = slot_base(slot_n) + ADDR_W'(len_r[slot_n]) - ADDR_W'(1);

    always_comb begin
        state_n  = state_r;
        slot_n   = slot_r;
        pos_n    = pos_r;
        loop_evt = 1'b0;
        rec_clr  = 1'b0;
        case (state_r)
            ST_INIT: if (i_init_done) state_n = ST_IDLE;
            ST_IDLE: begin
                if (i_start) begin
                    slot_n = i_slot;
                    if (!i_mode) begin
                        state_n = ST_RECORD;
                        rec_clr = 1'b1;
                        pos_n   = slot_base(i_slot);
                    end else if (len_r[i_slot] != '0) begin
                        state_n = ST_PLAY;
                        pos_n   = slot_base(i_slot);
                    end
                end
            end
            ST_RECORD: begin
                // Position follows the recorder so the timer shows elapsed record time.
                pos_n = i_rec_addr;
                if (i_stop || i_rec_done || (i_rec_addr == rec_limit)) state_n = ST_IDLE;
            end
            ST_PLAY: begin
                pos_n = i_play_addr;
                if (i_stop) begin
                    state_n = ST_IDLE;
                end else if (i_start) begin
                    state_n = ST_PAUSE;
                end else if (i_play_done) begin
`ifdef LOOP_PLAY_EN
                    loop_evt = 1'b1;
                    pos_n    = base_r;
`else
                    state_n  = ST_IDLE;
`endif
                end
            end
            ST_PAUSE: begin
                if (i_stop)       state_n = ST_IDLE;
                else if (i_start) state_n = ST_PLAY;
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_INIT;
            slot_r       <= '0;
            pos_r        <= '0;
            o_init_start <= 1'b1;
            o_rec_start  <= 1'b0;
            o_play_start <= 1'b0;
            o_rec_base   <= '0;
            o_play_end   <= '0;
            o_addr_sel   <= 1'b0;
            o_timer      <= '0;
        end else begin
            state_r      <= state_n;
            slot_r       <= slot_n;
            pos_r        <= pos_n;
            o_init_start <= (state_n == ST_INIT);
            o_rec_start  <= (state_n == ST_RECORD);
            // A loop restart drops play_start for one cycle so the player re-arms.
            o_play_start <= (state_n == ST_PLAY) && !loop_evt;
            o_rec_base   <= slot_base(slot_n);
            o_play_end   <= play_end_n;
            o_addr_sel   <= (state_n == ST_PLAY) || (state_n == ST_PAUSE);
            if ((state_n == ST_INIT) || (state_n == ST_IDLE))
                o_timer <= '0;
            else
                o_timer <= 5'((pos_n - slot_base(slot_n)) >> SR_LOG2);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_SLOT; i++) len_r[i] <= '0;
        end else if (rec_clr) begin
            len_r[i_slot] <= '0;
        end else if (state_r == ST_RECORD) begin
            len_r[slot_r] <= rec_len;
        end
    end

    assign o_state      = state_r;
    assign o_play_begin = pos_r;
    assign o_speed_stat = spd_stat;

    rec_play_speed #(.MAX_SPEED(MAX_SPEED)) u_speed (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     ((state_r == ST_PLAY) || (state_r == ST_PAUSE)),
        .i_clr    (rec_clr),
        .i_up     (i_up),
        .i_down   (i_down),
        .o_stat   (spd_stat),
        .o_factor (o_speed_factor),
        .o_code   (o_speed)
    );

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: scenario tasks drive recorder/player/buttons and
// compare against a slot-length table and a signed-integer speed model.
module tb_rec_play_ctrl;

    localparam int ADDR_W  = 20;
    localparam int SLOT_W  = 2;
    localparam int MAX_SPD = 8;
    localparam int SR_LOG2 = 15;
    localparam int OFS_W   = ADDR_W - SLOT_W;
    localparam int SLOT_SZ = 1 << OFS_W;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 0, i_stop = 0, i_up = 0, i_down = 0, i_mode = 0;
    logic [SLOT_W-1:0] i_slot = '0;
    logic              o_init_start, i_init_done = 0;
    logic              o_rec_start;
    logic [ADDR_W-1:0] o_rec_base, i_rec_addr = '0;
    logic              i_rec_done = 0;
    logic              o_play_start;
    logic [ADDR_W-1:0] o_play_begin, o_play_end, i_play_addr = '0;
    logic [4:0]        o_speed;
    logic              i_play_done = 0;
    logic              o_addr_sel;
    logic [2:0]        o_state;
    logic [1:0]        o_speed_stat;
    logic [4:0]        o_speed_factor, o_timer;

    rec_play_ctrl #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .MAX_SPEED(MAX_SPD), .SR_LOG2(SR_LOG2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop), .i_up(i_up),
        .i_down(i_down), .i_mode(i_mode), .i_slot(i_slot),
        .o_init_start(o_init_start), .i_init_done(i_init_done),
        .o_rec_start(o_rec_start), .o_rec_base(o_rec_base), .i_rec_addr(i_rec_addr),
        .i_rec_done(i_rec_done),
        .o_play_start(o_play_start), .o_play_begin(o_play_begin), .o_play_end(o_play_end),
        .o_speed(o_speed), .i_play_addr(i_play_addr), .i_play_done(i_play_done),
        .o_addr_sel(o_addr_sel), .o_state(o_state), .o_speed_stat(o_speed_stat),
        .o_speed_factor(o_speed_factor), .o_timer(o_timer)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int m_len [4];
    int m_v = 1;   // 1 = normal, +f = fast by f, -f = slow by f

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int spd_up(input int v);
        if (v == 1)  return 2;
        if (v >= 2)  return (v < MAX_SPD) ? v + 1 : MAX_SPD;
        if (v == -2) return 1;
        return v + 1;
    endfunction

    function automatic int spd_down(input int v);
        if (v == 1)  return -2;
        if (v <= -2) return (v > -MAX_SPD) ? v - 1 : -MAX_SPD;
        if (v == 2)  return 1;
        return v - 1;
    endfunction

    task automatic chk_speed();
        check("spd_factor", o_speed_factor, iabs(m_v));
        check("spd_stat", o_speed_stat, (m_v == 1) ? 0 : ((m_v > 0) ? 1 : 2));
        check("spd_code", o_speed, ((m_v < 0) ? 16 : 0) + iabs(m_v) - 1);
    endtask

    task automatic spd_pulse(input bit up, input bit dn, input bit active);
        i_up = up; i_down = dn;
        tick();
        i_up = 0; i_down = 0;
        if (active && (up ^ dn)) m_v = up ? spd_up(m_v) : spd_down(m_v);
        chk_speed();
    endtask

    // kind: 0 = stop button, 1 = recorder done, 2 = run into the slot limit
    task automatic record(input int s, input int n, input int stride, input int kind);
        int base, off;
        base = s << OFS_W;
        off = 0;
        i_mode = 0; i_slot = s[SLOT_W-1:0]; i_rec_addr = base[ADDR_W-1:0]; i_start = 1;
        tick();
        i_start = 0;
        m_v = 1;
        check("rec_state", o_state, 3);
        check("rec_start", o_rec_start, 1);
        check("rec_base", o_rec_base, base);
        check("rec_sel", o_addr_sel, 0);
        chk_speed();
        for (int k = 0; k < n; k++) begin
            off = (kind == 2 && k == n - 1) ? SLOT_SZ - 1 : k * stride;
            i_rec_addr = ADDR_W'(base + off);
            if (k == n - 1) begin
                if (kind == 0) i_stop = 1;
                if (kind == 1) i_rec_done = 1;
            end
            tick();
            i_stop = 0; i_rec_done = 0;
            if (k < n - 1) begin
                check("rec_hold", o_state, 3);
                check("rec_timer", o_timer, (off >> SR_LOG2) & 31);
            end
        end
        m_len[s] = off + 1;
        check("rec_exit_state", o_state, 1);
        check("rec_exit_start", o_rec_start, 0);
    endtask

    task automatic play_go(input int s);
        int base;
        base = s << OFS_W;
        i_mode = 1; i_slot = s[SLOT_W-1:0]; i_start = 1;
        tick();
        i_start = 0;
        if (m_len[s] == 0) begin
            check("reject_state", o_state, 1);
            check("reject_pstart", o_play_start, 0);
        end else begin
            check("play_state", o_state, 2);
            check("play_start", o_play_start, 1);
            check("play_sel", o_addr_sel, 1);
            check("play_begin", o_play_begin, base);
            check("play_end", o_play_end, base + m_len[s] - 1);
            check("play_timer0", o_timer, 0);
        end
    endtask

    task automatic play_track(input int s, input int n);
        int base, a;
        base = s << OFS_W;
        for (int k = 0; k < n; k++) begin
            a = base + int'($urandom_range(0, m_len[s] - 1));
            i_play_addr = a[ADDR_W-1:0];
            tick();
            check("track_pos", o_play_begin, a);
            check("track_timer", o_timer, ((a - base) >> SR_LOG2) & 31);
        end
    endtask

    task automatic stop_play(input bit with_start);
        i_stop = 1; i_start = with_start;
        tick();
        i_stop = 0; i_start = 0;
        check("stop_state", o_state, 1);
        check("stop_sel", o_addr_sel, 0);
        check("stop_pstart", o_play_start, 0);
        check("stop_timer", o_timer, 0);
    endtask

    task automatic pause_resume(input int s);
        int base, a, b;
        base = s << OFS_W;
        a = base + int'($urandom_range(0, m_len[s] - 1));
        i_play_addr = a[ADDR_W-1:0]; i_start = 1;
        tick();
        i_start = 0;
        check("pause_state", o_state, 4);
        check("pause_pstart", o_play_start, 0);
        check("pause_sel", o_addr_sel, 1);
        check("pause_pos", o_play_begin, a);
        b = base + int'($urandom_range(0, m_len[s] - 1));
        i_play_addr = b[ADDR_W-1:0];
        repeat (3) tick();
        check("pause_hold", o_play_begin, a);
        spd_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        i_start = 1;
        tick();
        i_start = 0;
        check("resume_state", o_state, 2);
        check("resume_pstart", o_play_start, 1);
        check("resume_begin", o_play_begin, a);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_len[i] = 0;
        repeat (2) tick();
        check("rst_state", o_state, 0);
        check("rst_init", o_init_start, 1);
        check("rst_rec", o_rec_start, 0);
        check("rst_play", o_play_start, 0);
        check("rst_sel", o_addr_sel, 0);
        check("rst_timer", o_timer, 0);
        chk_speed();
        i_rst = 0;
        repeat (10) tick();
        check("init_wait_state", o_state, 0);
        check("init_wait_start", o_init_start, 1);
        i_init_done = 1;
        tick();
        i_init_done = 0;
        check("init_done_state", o_state, 1);
        check("init_done_start", o_init_start, 0);

        play_go(3);
        spd_pulse(1, 0, 0);

        record(2, 100, 1, 0);
        play_go(2);
        play_track(2, 5);
        repeat (9) spd_pulse(1, 0, 1);
        check("spd_max_code", o_speed, 5'h07);
        repeat (7) spd_pulse(0, 1, 1);
        check("spd_back_normal", o_speed_factor, 1);
        spd_pulse(1, 1, 1);
        repeat (20) spd_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        pause_resume(2);
        play_track(2, 2);
        stop_play(1);
        chk_speed();

        record(1, 5, 1000, 2);
        play_go(1);
        check("full_end", o_play_end, 20'h7FFFF);
        play_track(1, 3);
        i_play_addr = 20'h7FFFF;
        tick();
        check("full_timer", o_timer, 7);
        i_play_done = 1;
        tick();
        i_play_done = 0;
`ifdef LOOP_PLAY_EN
        check("loop_state", o_state, 2);
        check("loop_pstart_low", o_play_start, 0);
        check("loop_pos", o_play_begin, 20'h40000);
        check("loop_timer", o_timer, 0);
        i_play_addr = 20'h40000;
        tick();
        check("loop_pstart_high", o_play_start, 1);
        stop_play(0);
`else
        check("done_state", o_state, 1);
        check("done_sel", o_addr_sel, 0);
        check("done_pstart", o_play_start, 0);
`endif

        play_go(2);
        i_play_addr = 20'h80010; i_start = 1;
        tick();
        i_start = 0;
        check("pause2_state", o_state, 4);
        stop_play(1);

        for (int it = 0; it < 4; it++) begin
            int s;
            s = int'($urandom_range(0, 3));
            record(s, int'($urandom_range(2, 20)), int'($urandom_range(1, 3000)), int'($urandom_range(0, 1)));
            play_go(s);
            play_track(s, 4);
            repeat (5) spd_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            stop_play(0);
        end

        play_go(2);
        play_track(2, 2);
        #2 i_rst = 1;
        #1;
        for (int i = 0; i < 4; i++) m_len[i] = 0;
        m_v = 1;
        check("midrst_state", o_state, 0);
        check("midrst_init", o_init_start, 1);
        check("midrst_pstart", o_play_start, 0);
        check("midrst_sel", o_addr_sel, 0);
        check("midrst_timer", o_timer, 0);
        chk_speed();
        tick();
        i_rst = 0;
        i_init_done = 1;
        tick();
        i_init_done = 0;
        check("reinit_state", o_state, 1);
        play_go(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
